regfile_dump_reader: RTL and testbench

//  Debug reader at the far end of the register file's read port: on a start request it walks

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_dump_reader.sv | 132 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the dump-reader FSM state type.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        DONE
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Debug reader that walks the register file read port and streams each register
// out over a valid/ready handshake, one word per LOAD/HOLD pair.
module regfile_dump_reader #(
    parameter int NUM_REGS  = regfile_pkg::NUM_REGS,
    parameter int ADDR_W    = regfile_pkg::ADDR_W,
    parameter int DATA_W    = regfile_pkg::DATA_W,
    parameter int FIRST_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    dump_state_t       r_state;
    dump_state_t       w_nextState;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_outData;
    logic [ADDR_W-1:0] r_outIndex;
    logic              r_outLast;
    logic              r_outValid;

    logic              w_handshake;
    logic              w_load;
    logic              w_advance;
    logic              w_restart;
    logic              w_clearValid;

    assign w_handshake = r_outValid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Abort overrides any handshake in the same cycle, so it is tested first in every busy state.
    always_comb begin
        w_nextState  = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_restart    = 1'b0;
        w_clearValid = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_nextState = LOAD;
                    w_restart   = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    w_nextState = IDLE;
                    w_restart   = 1'b1;
                end else begin
                    w_nextState = HOLD;
                    w_load      = 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    w_nextState  = IDLE;
                    w_restart    = 1'b1;
                    w_clearValid = 1'b1;
                end else if (w_handshake) begin
                    w_clearValid = 1'b1;
                    if (r_outLast) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = LOAD;
                        w_advance   = 1'b1;
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
                w_restart   = 1'b1;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= FIRST_IDX;
            r_outData  <= '0;
            r_outIndex <= '0;
            r_outLast  <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            if (w_restart) begin
                r_idx <= FIRST_IDX;
            end else if (w_advance) begin
                r_idx <= r_idx + ADDR_W'(1);
            end
            if (w_load) begin
                r_outData  <= rd_data;
                r_outIndex <= r_idx;
                r_outLast  <= (r_idx == LAST_IDX);
                r_outValid <= 1'b1;
            end else if (w_clearValid) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign rd_addr   = r_idx;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_index = r_outIndex;
    assign out_last  = r_outLast;
    assign busy      = (r_state == LOAD) || (r_state == HOLD);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: two instances (FIRST_REG 0 and 1) share a register file
// array and all inputs; every accepted word is compared against a snapshot of the array.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        outReady;
    logic [31:0] regs [32];

    logic [4:0]  rdAddrA, outIndexA, rdAddrB, outIndexB;
    logic [31:0] rdDataA, outDataA, rdDataB, outDataB;
    logic        outValidA, outLastA, busyA, doneA;
    logic        outValidB, outLastB, busyB, doneB;

    int testsRun  = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    assign rdDataA = regs[rdAddrA];
    assign rdDataB = regs[rdAddrB];

    regfile_dump_reader #(.FIRST_REG(0)) dutA (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rd_addr(rdAddrA), .rd_data(rdDataA),
        .out_valid(outValidA), .out_ready(outReady), .out_data(outDataA),
        .out_index(outIndexA), .out_last(outLastA), .busy(busyA), .done(doneA)
    );

    regfile_dump_reader #(.FIRST_REG(1)) dutB (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rd_addr(rdAddrB), .rd_data(rdDataB),
        .out_valid(outValidB), .out_ready(outReady), .out_data(outDataB),
        .out_index(outIndexB), .out_last(outLastB), .busy(busyB), .done(doneB)
    );

    // Runs one full dump and checks both instances cycle by cycle against the snapshot.
    task automatic runDump(input int readyPct, input int stallIdx, input bit noise, input bit coreWrite);
        logic [31:0] snap [32];
        int expA = 0, expB = 1, cyc, stallCnt = 0, firstValidA = -1;
        bit pendA = 0, pendB = 0, finA = 0, finB = 0, wrote = 0, ready;
        bit prevStallA = 0, prevStallB = 0;
        logic [31:0] hDataA, hDataB;
        logic [4:0]  hIdxA, hIdxB;
        logic        hLastA, hLastB;
        for (int i = 0; i < 32; i++) snap[i] = regs[i];
        @(negedge clk);
        start = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!(finA && finB) && cyc < 600) begin
            testsRun++;
            if (doneA !== pendA) begin
                failCount++;
                $display("[TB] FAIL doneA cyc %0d: got %b expected %b", cyc, doneA, pendA);
            end
            testsRun++;
            if (doneB !== pendB) begin
                failCount++;
                $display("[TB] FAIL doneB cyc %0d: got %b expected %b", cyc, doneB, pendB);
            end
            if (pendA) finA = 1;
            if (pendB) finB = 1;
            pendA = 0;
            pendB = 0;
            if (prevStallA) begin
                testsRun++;
                if (outValidA !== 1'b1 || outDataA !== hDataA || outIndexA !== hIdxA || outLastA !== hLastA) begin
                    failCount++;
                    $display("[TB] FAIL holdA: got v=%b d=%h i=%0d l=%b expected v=1 d=%h i=%0d l=%b",
                             outValidA, outDataA, outIndexA, outLastA, hDataA, hIdxA, hLastA);
                end
            end
            if (prevStallB) begin
                testsRun++;
                if (outValidB !== 1'b1 || outDataB !== hDataB || outIndexB !== hIdxB || outLastB !== hLastB) begin
                    failCount++;
                    $display("[TB] FAIL holdB: got v=%b d=%h i=%0d l=%b expected v=1 d=%h i=%0d l=%b",
                             outValidB, outDataB, outIndexB, outLastB, hDataB, hIdxB, hLastB);
                end
            end
            if (outValidA === 1'b1) begin
                if (firstValidA < 0) firstValidA = cyc;
                testsRun++;
                if (rdAddrA !== outIndexA) begin
                    failCount++;
                    $display("[TB] FAIL rdAddrHoldA: got %0d expected %0d", rdAddrA, outIndexA);
                end
            end

            ready = ($urandom_range(99) < readyPct);
            if (outValidA && outIndexA == stallIdx && stallCnt < 5) begin
                ready = 0;
                stallCnt++;
            end
            if (coreWrite && outValidA && outIndexA == 5 && !wrote) begin
                regs[5] = 32'h1234;
                wrote = 1;
                ready = 0;
            end
            outReady = ready;
            start = noise && outValidA && (outIndexA < 25) && ($urandom_range(1) == 1);

            prevStallA = outValidA && !ready;
            prevStallB = outValidB && !ready;
            hDataA = outDataA; hIdxA = outIndexA; hLastA = outLastA;
            hDataB = outDataB; hIdxB = outIndexB; hLastB = outLastB;

            if (outValidA && ready) begin
                testsRun++;
                if (expA > 31) begin
                    failCount++;
                    $display("[TB] FAIL extraWordA: got index %0d expected no word", outIndexA);
                end else if (outIndexA !== 5'(expA) || outDataA !== snap[expA] || outLastA !== (expA == 31)) begin
                    failCount++;
                    $display("[TB] FAIL wordA: got i=%0d d=%h l=%b expected i=%0d d=%h l=%b",
                             outIndexA, outDataA, outLastA, expA, snap[expA], (expA == 31));
                end
                if (outLastA) pendA = 1;
                expA++;
            end
            if (outValidB && ready) begin
                testsRun++;
                if (expB > 31) begin
                    failCount++;
                    $display("[TB] FAIL extraWordB: got index %0d expected no word", outIndexB);
                end else if (outIndexB !== 5'(expB) || outDataB !== snap[expB] || outLastB !== (expB == 31)) begin
                    failCount++;
                    $display("[TB] FAIL wordB: got i=%0d d=%h l=%b expected i=%0d d=%h l=%b",
                             outIndexB, outDataB, outLastB, expB, snap[expB], (expB == 31));
                end
                if (outLastB) pendB = 1;
                expB++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        outReady = 1'b0;
        testsRun++;
        if (!(finA && finB)) begin
            failCount++;
            $display("[TB] FAIL dumpTimeout: got finA=%b finB=%b expected both 1", finA, finB);
        end
        testsRun++;
        if (expA != 32 || expB != 32) begin
            failCount++;
            $display("[TB] FAIL wordCount: got A=%0d B=%0d expected A=32 B=31", expA, expB - 1);
        end
        testsRun++;
        if (firstValidA != 2) begin
            failCount++;
            $display("[TB] FAIL latency: got %0d expected 2", firstValidA);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        testsRun++;
        if (rdAddrA !== 5'd0 || rdAddrB !== 5'd1) begin
            failCount++;
            $display("[TB] FAIL resetRdAddr: got A=%0d B=%0d expected A=0 B=1", rdAddrA, rdAddrB);
        end
        testsRun++;
        if ({outValidA, outLastA, busyA, doneA, outValidB, outLastB, busyB, doneB} !== 8'b0) begin
            failCount++;
            $display("[TB] FAIL resetFlags: got %b expected 00000000",
                     {outValidA, outLastA, busyA, doneA, outValidB, outLastB, busyB, doneB});
        end
        testsRun++;
        if (outDataA !== 32'd0 || outIndexA !== 5'd0 || outDataB !== 32'd0 || outIndexB !== 5'd0) begin
            failCount++;
            $display("[TB] FAIL resetData: got dA=%h iA=%0d dB=%h iB=%0d expected zeros",
                     outDataA, outIndexA, outDataB, outIndexB);
        end
    endtask

    task automatic test_walk();
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
        runDump(100, -1, 0, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        runDump(100, 3, 0, 0);
    endtask

    task automatic test_first_reg();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hDEAD_0000;
        runDump(70, -1, 0, 0);
        testsRun++;
        if (rdAddrB !== 5'd1 || busyB !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL firstRegIdle: got rdAddr=%0d busy=%b expected rdAddr=1 busy=0", rdAddrB, busyB);
        end
    endtask

    task automatic test_abort();
        int cyc = 0;
        bit hit = 0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        @(negedge clk);
        start = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!hit && cyc < 200) begin
            if (outValidA && outIndexA == 10) hit = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        testsRun++;
        if (!hit) begin
            failCount++;
            $display("[TB] FAIL abortReach: got no HOLD at index 10 expected one within 200 cycles");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        outReady = 1'b0;
        testsRun++;
        if (outValidA !== 1'b0 || busyA !== 1'b0 || doneA !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL abortA: got v=%b busy=%b done=%b expected 0 0 0", outValidA, busyA, doneA);
        end
        testsRun++;
        if (outValidB !== 1'b0 || busyB !== 1'b0 || doneB !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL abortB: got v=%b busy=%b done=%b expected 0 0 0", outValidB, busyB, doneB);
        end
        @(negedge clk);
        testsRun++;
        if (outValidA !== 1'b0 || busyA !== 1'b0 || doneA !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL abortIdle: got v=%b busy=%b done=%b expected 0 0 0", outValidA, busyA, doneA);
        end
        runDump(100, -1, 0, 0);
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        bit hit = 0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        @(negedge clk);
        start = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!hit && cyc < 200) begin
            if (outValidA && outIndexA == 6) hit = 1;
            @(negedge clk);
            cyc++;
        end
        testsRun++;
        if (!hit || rdAddrA !== 5'd7 || outValidA !== 1'b0 || busyA !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL loadSeven: got hit=%b rdAddr=%0d v=%b busy=%b expected 1 7 0 1",
                     hit, rdAddrA, outValidA, busyA);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        outReady = 1'b0;
        testsRun++;
        if (rdAddrA !== 5'd0 || rdAddrB !== 5'd1 ||
            {outValidA, outLastA, busyA, doneA, outValidB, outLastB, busyB, doneB} !== 8'b0 ||
            outDataA !== 32'd0 || outIndexA !== 5'd0 || outDataB !== 32'd0 || outIndexB !== 5'd0) begin
            failCount++;
            $display("[TB] FAIL midReset: got rdA=%0d rdB=%0d flags=%b dA=%h iA=%0d expected 0 1 00000000 0 0",
                     rdAddrA, rdAddrB, {outValidA, outLastA, busyA, doneA, outValidB, outLastB, busyB, doneB},
                     outDataA, outIndexA);
        end
        @(negedge clk);
        runDump(100, -1, 0, 0);
    endtask

    task automatic test_start_busy();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[5] = 32'h5555_AAAA;
        runDump(80, -1, 1, 1);
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            runDump(int'($urandom_range(100, 30)), int'($urandom_range(31)), 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        outReady = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        test_reset();
        test_walk();
        test_backpressure();
        test_first_reg();
        test_abort();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
